eq_lut_builder: RTL and testbench
=================================

Name: eq_lut_builder

Overview:
Downstream consumer of the per-bin cumulative histogram counters. After a frame has been accumulated, it reads the 2^PixelSize CDF values and computes the histogram-equalization mapping round((cdf - cdf_min)*(L-1)/(N - cdf_min)). It uses a sequential restoring divider and writes each result into the equalization LUT RAM that the pixel-remap stage uses.

Parameters:
PixelSize, 8, pixel bit width; L = 2^PixelSize bins
TOTAL_PIXELS, 640*480, pixels per frame (N)
histoWidth, $clog2(640*480), CDF counter width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle pulse: begin LUT build (CDF counters frozen)
cdf_addr  output  PixelSize  bin index to CDF mux
cdf_data  input  histoWidth  CDF of bin cdf_addr; valid exactly 1 cycle after cdf_addr is presented
lut_wr_en  output  1  LUT write strobe
lut_wr_addr  output  PixelSize  LUT address
lut_wr_data  output  PixelSize  mapped pixel value
busy  output  1  high from cycle after accepted start until done
done  output  1  1-cycle pulse after last LUT write

Behaviour:
- Reset: all outputs 0; state IDLE; cdf_min, denominator and divider registers cleared. Reset mid-operation aborts immediately; no further writes; no done pulse.
- IDLE: start=1 -> FIND_MIN with bin=0; busy=1 next cycle. start while busy is ignored.
- FIND_MIN: present cdf_addr=bin, sample cdf_data next cycle, 2 cycles per bin.
  - First nonzero value -> cdf_min, then go to MAP.
  - All L bins zero -> cdf_min=0, then go to MAP.
  - denom = TOTAL_PIXELS - cdf_min, in histoWidth bits; saturates at 0 if cdf_min > TOTAL_PIXELS.
- MAP, per bin k = 0..L-1, in order:
  - RD: cdf_addr=k.
  - LATCH: capture cdf_data; numerator = (cdf - cdf_min)*(L-1) [+ denom>>1, see option], width histoWidth+PixelSize (NUM_W).
  - DIV: restoring divide by denom, exactly NUM_W cycles, MSB first.
  - WR: lut_wr_en=1 for exactly one cycle, lut_wr_addr=k, lut_wr_data=result.
  - Per bin: NUM_W+3 cycles; no pipelining across bins.
- Result priority, first match wins:
  1. cdf==0 -> 0.
  2. denom==0 -> L-1.
  3. cdf<=cdf_min -> 0.
  4. Otherwise quotient, saturated to L-1.
  - Cases 1-3 still take the full NUM_W+3 cycles, for fixed timing.
- After WR of bin L-1: done=1 for one cycle, the same cycle busy falls; state returns to IDLE.
- Between WR strobes, lut_wr_en=0. lut_wr_addr/lut_wr_data hold their last values.
- Total latency, start to done: 2*(index of first nonzero bin + 1) + L*(NUM_W+3) + 1 cycles. All-zero case: 2L + L*(NUM_W+3) + 1.

Optional Feature:
EQ_LUT_ROUND_EN: defined -> add (denom>>1) to the numerator before division (round-half-up). Undefined -> plain floor division, no adder. Cycle timing is identical either way.

Test Plan:
1. Uniform ramp, defaults: cdf[k]=1200*(k+1) -> cdf_min=1200, denom=306000; lut[k]=k for all 256 bins; exactly 256 lut_wr_en strobes, addresses 0..255 ascending; done once.
2. Flat image, all pixels=100: cdf[k]=0 for k<100, 307200 otherwise -> denom=0; lut[0..99]=0, lut[100..255]=255.
3. Bimodal: cdf[0..254]=153600, cdf[255]=307200 -> lut[0..254]=0, lut[255]=255.
4. TOTAL_PIXELS=5 override, cdf[0]=1, cdf[1]=2, cdf[2]=3, cdf[3..255]=5 -> with EQ_LUT_ROUND_EN: lut[1]=64, lut[2]=128, lut[3]=255; without: lut[1]=63, lut[2]=127, lut[3]=255.
5. Control: start pulsed again mid-MAP -> no restart, write sequence unchanged. rst asserted during DIV of bin 40 -> next cycle busy=0, lut_wr_en=0, done stays 0. A fresh start then completes normally.
6. Timing, defaults with first nonzero bin 0: done asserted exactly 2 + 256*(27+3) + 1 = 7683 cycles after the start cycle. No write strobes while in IDLE.

Source files
------------

// File: rtl/eq_lut_builder.sv
// Builds the histogram-equalization LUT from frozen per-bin CDF counters using a restoring divider.
// Optional macro EQ_LUT_ROUND_EN: round-half-up mapping (adds denom>>1 to the numerator).
module eq_lut_builder #(
  parameter int PixelSize    = 8,
  parameter int TOTAL_PIXELS = 640*480,
  parameter int histoWidth   = $clog2(640*480)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [PixelSize-1:0]  cdf_addr,
  input  logic [histoWidth-1:0] cdf_data,
  output logic                  lut_wr_en,
  output logic [PixelSize-1:0]  lut_wr_addr,
  output logic [PixelSize-1:0]  lut_wr_data,
  output logic                  busy,
  output logic                  done
);
  localparam int NUM_W = histoWidth + PixelSize;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [histoWidth-1:0] TOT_W    = histoWidth'(TOTAL_PIXELS);
  localparam logic [NUM_W-1:0]      LM1_W    = NUM_W'((1 << PixelSize) - 1);
  localparam logic [PixelSize-1:0]  LAST_BIN = {PixelSize{1'b1}};
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NUM_W - 1);

  // Handshake: cdf_addr is presented for a full cycle and cdf_data answers one cycle later;
  // lut_wr_en is a one-cycle strobe with no backpressure.
  typedef enum logic [2:0] {
    S_IDLE, S_FIND_RD, S_FIND_SMP, S_MAP_RD, S_MAP_LATCH, S_MAP_DIV, S_MAP_WR
  } state_t;

  state_t                 state_q, state_d;
  logic [PixelSize-1:0]   bin_q, bin_d;
  logic [histoWidth-1:0]  cdf_min_q, cdf_min_d;
  logic [histoWidth-1:0]  denom_q, denom_d;
  logic [histoWidth-1:0]  cdf_q, cdf_d;
  logic [histoWidth-1:0]  rem_q, rem_d;
  logic [NUM_W-1:0]       num_q, num_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PixelSize-1:0]   wr_addr_q, wr_addr_d;
  logic [PixelSize-1:0]   wr_data_q, wr_data_d;
  logic                   done_q, done_d;

  logic [histoWidth:0]    rem_shift;
  logic [histoWidth:0]    rem_sub;
  logic [NUM_W-1:0]       product;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      cdf_min_q <= '0;
      denom_q   <= '0;
      cdf_q     <= '0;
      rem_q     <= '0;
      num_q     <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      cdf_min_q <= cdf_min_d;
      denom_q   <= denom_d;
      cdf_q     <= cdf_d;
      rem_q     <= rem_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    cdf_min_d = cdf_min_q;
    denom_d   = denom_q;
    cdf_d     = cdf_q;
    rem_d     = rem_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    rem_shift = {rem_q, num_q[NUM_W-1]};
    rem_sub   = rem_shift - {1'b0, denom_q};
    product   = NUM_W'(cdf_data - cdf_min_q) * LM1_W;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d     = '0;
          cdf_min_d = '0;
          state_d   = S_FIND_RD;
        end
      end
      S_FIND_RD: state_d = S_FIND_SMP;
      S_FIND_SMP: begin
        if (cdf_data != '0) begin
          cdf_min_d = cdf_data;
          denom_d   = (cdf_data > TOT_W) ? '0 : TOT_W - cdf_data;
          bin_d     = '0;
          state_d   = S_MAP_RD;
        end else if (bin_q == LAST_BIN) begin
          cdf_min_d = '0;
          denom_d   = TOT_W;
          bin_d     = '0;
          state_d   = S_MAP_RD;
        end else begin
          bin_d   = bin_q + PixelSize'(1);
          state_d = S_FIND_RD;
        end
      end
      S_MAP_RD: state_d = S_MAP_LATCH;
      S_MAP_LATCH: begin
        cdf_d = cdf_data;
`ifdef EQ_LUT_ROUND_EN
        num_d = product + NUM_W'(denom_q >> 1);
`else
        num_d = product;
`endif
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_MAP_DIV;
      end
      S_MAP_DIV: begin
        // One restoring step per cycle; quotient bits shift into num from the LSB.
        if (!rem_sub[histoWidth]) begin
          rem_d = rem_sub[histoWidth-1:0];
          num_d = {num_q[NUM_W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[histoWidth-1:0];
          num_d = {num_q[NUM_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          wr_addr_d = bin_q;
          if (cdf_q == '0)                      wr_data_d = '0;
          else if (denom_q == '0)               wr_data_d = LAST_BIN;
          else if (cdf_q <= cdf_min_q)          wr_data_d = '0;
          else if (|num_d[NUM_W-1:PixelSize])   wr_data_d = LAST_BIN;
          else                                  wr_data_d = num_d[PixelSize-1:0];
          state_d = S_MAP_WR;
        end
      end
      S_MAP_WR: begin
        if (bin_q == LAST_BIN) begin
          bin_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          bin_d   = bin_q + PixelSize'(1);
          state_d = S_MAP_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cdf_addr    = bin_q;
  assign lut_wr_en   = (state_q == S_MAP_WR);
  assign lut_wr_addr = wr_addr_q;
  assign lut_wr_data = wr_data_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_eq_lut_builder.sv
// Self-checking bench for eq_lut_builder: spec-level LUT model, per-strobe scoreboard, timing checks.
module tb_eq_lut_builder;
  localparam int PS = 8;
  localparam int HW = 19;
  localparam int L  = 256;
  localparam int PER_BIN = HW + PS + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [PS-1:0] cdf_addr_a, cdf_addr_b;
  logic [HW-1:0] cdf_data_a = '0, cdf_data_b = '0;
  logic          lut_wr_en_a, lut_wr_en_b;
  logic [PS-1:0] lut_wr_addr_a, lut_wr_addr_b;
  logic [PS-1:0] lut_wr_data_a, lut_wr_data_b;
  logic          busy_a, busy_b, done_a, done_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt_a = 0, done_cnt_b = 0;

  int mem_a [0:L-1];
  int mem_b [0:L-1];
  int model_cdf [0:L-1];
  logic [PS-1:0] model_lut [0:L-1];
  int model_first;

  logic [2*PS-1:0] exp_a[$];
  logic [2*PS-1:0] exp_b[$];

  eq_lut_builder u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .cdf_addr(cdf_addr_a), .cdf_data(cdf_data_a),
    .lut_wr_en(lut_wr_en_a), .lut_wr_addr(lut_wr_addr_a), .lut_wr_data(lut_wr_data_a),
    .busy(busy_a), .done(done_a)
  );

  eq_lut_builder #(.TOTAL_PIXELS(5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .cdf_addr(cdf_addr_b), .cdf_data(cdf_data_b),
    .lut_wr_en(lut_wr_en_b), .lut_wr_addr(lut_wr_addr_b), .lut_wr_data(lut_wr_data_b),
    .busy(busy_b), .done(done_b)
  );

  // Clock and reset-free cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Frozen CDF counter bank: data answers one cycle after the address
  always @(posedge clk) begin
    cdf_data_a <= HW'(mem_a[cdf_addr_a]);
    cdf_data_b <= HW'(mem_b[cdf_addr_b]);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mapping computed straight from the equalization formula and its priority rules
  task automatic run_model(input longint n);
    longint cmin, den, c, q, rnd;
    cmin = 0;
    model_first = -1;
    for (int k = 0; k < L; k++) begin
      if (model_first < 0 && model_cdf[k] != 0) begin
        model_first = k;
        cmin = model_cdf[k];
      end
    end
    den = (n > cmin) ? n - cmin : 0;
`ifdef EQ_LUT_ROUND_EN
    rnd = den / 2;
`else
    rnd = 0;
`endif
    for (int k = 0; k < L; k++) begin
      c = model_cdf[k];
      if (c == 0)          model_lut[k] = 8'd0;
      else if (den == 0)   model_lut[k] = 8'd255;
      else if (c <= cmin)  model_lut[k] = 8'd0;
      else begin
        q = ((c - cmin) * (L - 1) + rnd) / den;
        model_lut[k] = (q > L - 1) ? 8'd255 : PS'(q);
      end
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    logic [2*PS-1:0] e;
    if (!rst) begin
      if (lut_wr_en_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL a_write: got unexpected addr=%0d data=%0d expected no write", lut_wr_addr_a, lut_wr_data_a);
        end else begin
          e = exp_a.pop_front();
          if ({lut_wr_addr_a, lut_wr_data_a} !== e) begin
            errors++;
            $display("FAIL a_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     lut_wr_addr_a, lut_wr_data_a, e[2*PS-1:PS], e[PS-1:0]);
          end
        end
      end
      if (lut_wr_en_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_write: got unexpected addr=%0d data=%0d expected no write", lut_wr_addr_b, lut_wr_data_b);
        end else begin
          e = exp_b.pop_front();
          if ({lut_wr_addr_b, lut_wr_data_b} !== e) begin
            errors++;
            $display("FAIL b_write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                     lut_wr_addr_b, lut_wr_data_b, e[2*PS-1:PS], e[PS-1:0]);
          end
        end
      end
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  end

  // Driver: one full build on DUT a (sel=0) or DUT b (sel=1); optional stray start mid-MAP
  task automatic run_build(input bit sel, input string tag, input int restart_at);
    int t0, exp_lat;
    bit seen;
    model_cdf = sel ? mem_b : mem_a;
    run_model(sel ? 64'd5 : 64'd307200);
    for (int k = 0; k < L; k++) begin
      if (sel) exp_b.push_back({PS'(k), model_lut[k]});
      else     exp_a.push_back({PS'(k), model_lut[k]});
    end
    exp_lat = ((model_first < 0) ? 2 * L : 2 * (model_first + 1)) + L * PER_BIN + 1;
    done_cnt_a = 0;
    done_cnt_b = 0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_busy_after_start"}, sel ? busy_b : busy_a, 1);
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (sel) start_b = (i == restart_at); else start_a = (i == restart_at);
      if (sel ? done_b : done_a) begin
        seen = 1'b1;
        chk({tag, "_latency"}, cyc - t0, exp_lat);
        chk({tag, "_busy_at_done"}, sel ? busy_b : busy_a, 0);
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    repeat (20) @(negedge clk);
    chk({tag, "_writes_left"}, sel ? exp_b.size() : exp_a.size(), 0);
    chk({tag, "_done_count"}, sel ? done_cnt_b : done_cnt_a, 1);
    chk({tag, "_idle_busy"}, sel ? busy_b : busy_a, 0);
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < L; k++) mem_a[k] = 1200 * (k + 1);
  endtask

  initial begin
    bit seen;
    for (int k = 0; k < L; k++) begin
      mem_a[k] = 0;
      mem_b[k] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_wr_en", lut_wr_en_a, 0);
    chk("rst_wr_addr", lut_wr_addr_a, 0);
    chk("rst_wr_data", lut_wr_data_a, 0);
    chk("rst_cdf_addr", cdf_addr_a, 0);
    chk("rst_busy_b", busy_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Uniform ramp: identity mapping
    fill_ramp();
    model_cdf = mem_a;
    run_model(307200);
    chk("model_ramp_37", model_lut[37], 37);
    chk("model_ramp_255", model_lut[255], 255);
    run_build(1'b0, "ramp", -1);

    // Flat image: denominator collapses to zero
    for (int k = 0; k < L; k++) mem_a[k] = (k < 100) ? 0 : 307200;
    model_cdf = mem_a;
    run_model(307200);
    chk("model_flat_99", model_lut[99], 0);
    chk("model_flat_100", model_lut[100], 255);
    run_build(1'b0, "flat", -1);

    // Bimodal
    for (int k = 0; k < L; k++) mem_a[k] = (k < 255) ? 153600 : 307200;
    model_cdf = mem_a;
    run_model(307200);
    chk("model_bimodal_254", model_lut[254], 0);
    chk("model_bimodal_255", model_lut[255], 255);
    run_build(1'b0, "bimodal", -1);

    // Tiny frame on the N=5 instance exercises rounding behaviour
    for (int k = 0; k < L; k++) mem_b[k] = (k < 3) ? k + 1 : 5;
    model_cdf = mem_b;
    run_model(5);
    chk("model_small_0", model_lut[0], 0);
`ifdef EQ_LUT_ROUND_EN
    chk("model_small_1", model_lut[1], 64);
    chk("model_small_2", model_lut[2], 128);
`else
    chk("model_small_1", model_lut[1], 63);
    chk("model_small_2", model_lut[2], 127);
`endif
    chk("model_small_3", model_lut[3], 255);
    run_build(1'b1, "small", -1);

    // Stray start during MAP must not disturb the sequence
    fill_ramp();
    run_build(1'b0, "restart", 300);

    // Abort with reset during the divide of bin 40
    model_cdf = mem_a;
    run_model(307200);
    for (int k = 0; k < L; k++) exp_a.push_back({PS'(k), model_lut[k]});
    done_cnt_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (lut_wr_en_a && lut_wr_addr_a == 8'd39) seen = 1'b1;
    end
    chk("abort_reached_bin39", seen, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_a, 0);
    chk("abort_wr_en", lut_wr_en_a, 0);
    chk("abort_done", done_a, 0);
    exp_a.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt_a, 0);
    chk("abort_idle", busy_a, 0);

    // Fresh build after abort
    run_build(1'b0, "fresh", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
